wb_stream_dma_mc: RTL
=====================

Name: wb_stream_dma_mc

Overview:
Multi-channel stream-to-memory DMA writer. It takes NCH independent valid/ready data streams and buffers each one in its own single-clock FIFO. A round-robin arbiter drains the FIFOs as fixed-length incrementing Wishbone write bursts into one circular buffer per channel. Configuration arrives on plain ports, so a separate register block can be attached; the block sits between capture pipelines and the SDRAM Wishbone bus.

Parameters:
NCH, 2, number of stream channels (1..8)
WB_DW, 32, data width in bits (multiple of 8)
WB_AW, 32, byte address width
FIFO_AW, 4, per-channel FIFO depth is 2**FIFO_AW words
BURST_LEN, 8, words per burst; power of 2, <= 2**FIFO_AW

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wbm_adr_o  out  WB_AW  byte address
wbm_dat_o  out  WB_DW  write data
wbm_sel_o  out  WB_DW/8  all ones while cyc, else 0
wbm_we_o  out  1  equals wbm_cyc_o
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_cti_o  out  3  010 incrementing, 111 last beat
wbm_bte_o  out  2  constant 00
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  bus error
s_data_i  in  NCH*WB_DW  channel i data in bits [i*WB_DW +: WB_DW]
s_valid_i  in  NCH  stream valid
s_ready_o  out  NCH  stream ready
cfg_enable_i  in  NCH  channel enable
cfg_start_adr_i  in  NCH*WB_AW  buffer base byte address
cfg_buf_words_i  in  NCH*WB_AW  buffer size in words; nonzero multiple of BURST_LEN
irq_clr_i  in  NCH  clear pulse for irq_o
irq_o  out  NCH  sticky buffer-wrap interrupt
busy_o  out  NCH  channel enabled and not halted
err_o  out  1  sticky bus-error flag

Behaviour:
- Reset values: all outputs 0; FIFOs empty; offsets 0; state IDLE; last_grant = NCH-1. Reset takes effect immediately, including mid-burst (cyc/stb drop asynchronously).
- FIFO, one per channel:
  - First-word-fall-through; count width FIFO_AW+1.
  - s_ready_o[i] = enable & !halted & (count < 2**FIFO_AW).
  - Push on valid&ready. Pop only on an accepted beat. Push and pop in the same cycle leaves count unchanged.
- Channel disable (cfg_enable_i[i]=0):
  - If channel i is not in a burst, its FIFO is flushed, offset cleared to 0 and halted cleared, on every such cycle.
  - If disable arrives mid-burst, the burst completes first, then the flush happens.
- Arbitration, state IDLE:
  - Channel i is eligible when enable & !halted & count >= BURST_LEN.
  - Grant the first eligible channel searching from last_grant+1 cyclically.
  - Register the grant and the burst base address = start_adr + offset*(WB_DW/8), truncated to WB_AW bits. Configuration is sampled at that moment.
  - Next cycle: state BURST, cyc=stb=1. Latency from eligibility to first stb is 1 cycle.
- BURST:
  - wbm_adr_o = base + beat*(WB_DW/8); wbm_dat_o = granted FIFO head.
  - cti = 010 for beats 0..BURST_LEN-2, 111 for the last beat.
  - On ack: pop, beat+1, address advances the same cycle (back-to-back acks sustain one word/cycle).
  - On ack of the last beat: next cycle cyc=stb=0, state IDLE, offset += BURST_LEN.
    - If the new offset == buf_words, offset wraps to 0 and irq_o[i] is set.
  - At least one idle cycle separates bursts.
- Error: wbm_err_i during BURST (ack ignored if both asserted):
  - No pop; cyc drops next cycle; state IDLE.
  - err_o set; channel halted (busy_o low, s_ready_o low, never eligible).
  - A halted channel recovers only via disable/re-enable, which also flushes it.
  - err_o clears only on reset.
- irq_o[i] set by wrap, cleared by irq_clr_i[i]; a set in the same cycle as a clear wins.
- busy_o[i] = cfg_enable_i[i] & !halted[i], registered (1-cycle lag).

Test Plan:
- NCH=2, ch0 enabled (start 0x1000, buf 16 words); push 8 words 0xA0..0xA7 -> one burst at 0x1000..0x101C, cti 010×7 then 111, data in order, cyc low after the 8th ack.
- Push 16 more words on ch0 -> bursts at 0x1020, then wrap back to 0x1000; irq_o[0]=1 after the second wrap burst; irq_clr_i with a simultaneous wrap keeps irq_o=1.
- Both channels with >=8 words continuously, ch1 start 0x8000 -> grants alternate ch0, ch1, ch0, … with no channel starved; ch0 is first after reset.
- Slave holds ack low 3 cycles on beat 2 -> address, data and stb stable; no extra pop; FIFO count drops by exactly 8.
- wbm_err_i on beat 4 of a ch1 burst -> err_o=1, busy_o[1]=0, s_ready_o[1]=0, ch0 continues; toggle cfg_enable_i[1] -> FIFO empty, offset 0, busy_o[1]=1, err_o stays 1.
- Assert rst_n=0 mid-burst -> cyc/stb/irq/ready 0 immediately; after release, first burst lands at the start address with offset 0.

Source files
------------

// File: rtl/wb_stream_dma_mc.sv
// Multi-channel stream-to-memory DMA: per-channel FWFT FIFOs drained round-robin
// as fixed-length incrementing Wishbone write bursts into per-channel circular buffers.
//
// state   | meaning
// S_IDLE  | no bus cycle; arbitrate among eligible channels
// S_BURST | cyc/stb high, writing BURST_LEN beats from the granted FIFO
module wb_stream_dma_mc #(
  parameter int NCH       = 2,
  parameter int WB_DW     = 32,
  parameter int WB_AW     = 32,
  parameter int FIFO_AW   = 4,
  parameter int BURST_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [WB_AW-1:0]       wbm_adr_o,
  output logic [WB_DW-1:0]       wbm_dat_o,
  output logic [WB_DW/8-1:0]     wbm_sel_o,
  output logic                   wbm_we_o,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic [2:0]             wbm_cti_o,
  output logic [1:0]             wbm_bte_o,
  input  logic                   wbm_ack_i,
  input  logic                   wbm_err_i,
  input  logic [NCH*WB_DW-1:0]   s_data_i,
  input  logic [NCH-1:0]         s_valid_i,
  output logic [NCH-1:0]         s_ready_o,
  input  logic [NCH-1:0]         cfg_enable_i,
  input  logic [NCH*WB_AW-1:0]   cfg_start_adr_i,
  input  logic [NCH*WB_AW-1:0]   cfg_buf_words_i,
  input  logic [NCH-1:0]         irq_clr_i,
  output logic [NCH-1:0]         irq_o,
  output logic [NCH-1:0]         busy_o,
  output logic                   err_o
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int BYTES = WB_DW/8;
  localparam int GW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] BURST_CNT = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BURST_LEN-1);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                          state_q, state_d;
  logic [GW-1:0]                   grant_q, grant_d, last_grant_q, last_grant_d;
  logic [WB_AW-1:0]                base_q, base_d, bufw_q, bufw_d;
  logic [BW-1:0]                   beat_q, beat_d;
  logic [NCH-1:0][WB_AW-1:0]       offset_q, offset_d;
  logic [NCH-1:0]                  halted_q, halted_d, irq_q, irq_d, busy_q, busy_d;
  logic                            err_q, err_d;
  logic [NCH-1:0][FIFO_AW:0]       cnt_q, cnt_d;
  logic [NCH-1:0][FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [WB_DW-1:0]                mem [NCH][DEPTH];

  logic [NCH-1:0]                  ready, push, pop, flush, elig;
  logic                            in_burst, last_beat, found;
  logic [GW-1:0]                   pick, rr_idx;
  logic [GW:0]                     rr_sum;
  logic [WB_AW-1:0]                sel_start, sel_bufw, nxt_off;

  assign in_burst  = (state_q == S_BURST);
  assign last_beat = (beat_q == LAST_BEAT);

  // rst_n gates ready so the stream side sees no space while reset is held.
  always_comb begin
    ready = '0;
    push  = '0;
    elig  = '0;
    flush = '0;
    for (int i = 0; i < NCH; i++) begin
      ready[i] = rst_n & cfg_enable_i[i] & ~halted_q[i] & (cnt_q[i] < FULL_CNT);
      push[i]  = s_valid_i[i] & ready[i];
      elig[i]  = cfg_enable_i[i] & ~halted_q[i] & (cnt_q[i] >= BURST_CNT);
      flush[i] = ~cfg_enable_i[i] & ~(in_burst & (grant_q == GW'(i)));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    bufw_d       = bufw_q;
    beat_d       = beat_q;
    offset_d     = offset_q;
    halted_d     = halted_q;
    err_d        = err_q;
    irq_d        = irq_q & ~irq_clr_i;
    busy_d       = cfg_enable_i & ~halted_q;
    pop          = '0;
    found        = 1'b0;
    pick         = last_grant_q;
    rr_sum       = '0;
    rr_idx       = '0;
    sel_start    = '0;
    sel_bufw     = '0;
    nxt_off      = '0;

    for (int k = 1; k <= NCH; k++) begin
      rr_sum = {1'b0, last_grant_q} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(NCH)) rr_sum = rr_sum - (GW+1)'(NCH);
      rr_idx = rr_sum[GW-1:0];
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (pick == GW'(i)) begin
        sel_start = cfg_start_adr_i[i*WB_AW +: WB_AW];
        sel_bufw  = cfg_buf_words_i[i*WB_AW +: WB_AW];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_BURST;
          grant_d      = pick;
          last_grant_d = pick;
          base_d       = sel_start + offset_q[pick] * WB_AW'(BYTES);
          bufw_d       = sel_bufw;
          beat_d       = '0;
        end
      end
      S_BURST: begin
        nxt_off = offset_q[grant_q] + WB_AW'(BURST_LEN);
        if (wbm_err_i) begin
          state_d           = S_IDLE;
          err_d             = 1'b1;
          halted_d[grant_q] = 1'b1;
        end else if (wbm_ack_i) begin
          pop[grant_q] = 1'b1;
          beat_d       = beat_q + BW'(1);
          if (last_beat) begin
            state_d = S_IDLE;
            if (nxt_off == bufw_q) begin
              offset_d[grant_q] = '0;
              irq_d[grant_q]    = 1'b1;
            end else begin
              offset_d[grant_q] = nxt_off;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NCH; i++) begin
      if (flush[i]) begin
        offset_d[i] = '0;
        halted_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      if (flush[i]) begin
        cnt_d[i]    = '0;
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem[i][wr_ptr_q[i]] <= s_data_i[i*WB_DW +: WB_DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NCH-1);
      base_q       <= '0;
      bufw_q       <= '0;
      beat_q       <= '0;
      offset_q     <= '0;
      halted_q     <= '0;
      irq_q        <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      bufw_q       <= bufw_d;
      beat_q       <= beat_d;
      offset_q     <= offset_d;
      halted_q     <= halted_d;
      irq_q        <= irq_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_we_o  = in_burst;
  assign wbm_sel_o = {(WB_DW/8){in_burst}};
  assign wbm_cti_o = !in_burst ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
  assign wbm_bte_o = 2'b00;
  assign wbm_adr_o = in_burst ? base_q + WB_AW'(beat_q) * WB_AW'(BYTES) : '0;
  assign wbm_dat_o = in_burst ? mem[grant_q][rd_ptr_q[grant_q]] : '0;
  assign s_ready_o = ready;
  assign irq_o     = irq_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
endmodule
